flag_ctrl: RTL and testbench
============================

FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 Parameter STACK_DEPTH, default 4, sets the shadow-stack entry count (power of two, 2..16).
REQ-002 Parameter PTR_W, default 3, sets the stack pointer width, equal to clog2(STACK_DEPTH)+1.
REQ-003 CLK  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  is synchronous and active-high.
REQ-005 ALU_FWE  in  1  requests an ALU flag write this cycle.
REQ-006 ALU_FLAGS  in  4  holds the ALU result flags {CF,OF,NF,ZF}, with bit 3 = CF and bit 0 = ZF.
REQ-007 ALU_MASK  in  4  is a per-bit write enable for ALU_FLAGS; 1 means update that flag.
REQ-008 LD_FWE  in  1  requests an explicit full flag load (POPF/MOV-to-flags).
REQ-009 LD_FLAGS  in  4  holds the explicit load value.
REQ-010 SAVE  in  1  pushes the current flags onto the shadow stack (interrupt entry).
REQ-011 RESTORE  in  1  pops the shadow stack into the flags (interrupt return).
REQ-012 CLR_ERR  in  1  clears the sticky error.
REQ-013 COND  in  3  selects the branch condition.
REQ-014 FLAGS  out  4  is the registered flags {CF,OF,NF,ZF}.
REQ-015 TAKEN  out  1  is the combinational condition result, derived from FLAGS only.
REQ-016 STACK_EMPTY  out  1  indicates the stack count is 0.
REQ-017 STACK_FULL  out  1  indicates the stack count equals STACK_DEPTH.
REQ-018 ERR  out  1  is the sticky overflow/underflow error.

Function
REQ-019 The flag write source SHALL be chosen each cycle by priority: a valid RESTORE first, then LD_FWE, then ALU_FWE; lower sources are dropped that cycle, not queued.
REQ-020 An ALU write SHALL set FLAGS <= (FLAGS & ~ALU_MASK) | (ALU_FLAGS & ALU_MASK); ALU_MASK=0000 SHALL leave FLAGS unchanged.
REQ-021 An LD write SHALL set FLAGS <= LD_FLAGS on all four bits.
REQ-022 SAVE alone, not full: stack[count] <= FLAGS; count <= count+1; FLAGS unchanged unless a write from REQ-019 occurs in the same cycle.
REQ-023 The pushed value SHALL be FLAGS before any same-cycle write.
REQ-024 RESTORE alone, not empty: FLAGS <= stack[count-1]; count <= count-1.
REQ-025 SAVE and RESTORE together, not empty: swap, stack[count-1] <= FLAGS and FLAGS <= old stack[count-1]; count unchanged.
REQ-026 SAVE and RESTORE together on an empty stack: treat as underflow.
REQ-027 Underflow (RESTORE while empty) and overflow (SAVE while full): no stack or pointer change; ERR <= 1; a rejected RESTORE SHALL NOT block LD/ALU writes that cycle.
REQ-028 ERR SHALL stay set until CLR_ERR or RESET; if CLR_ERR and a new error occur in the same cycle, ERR ends at 1.
REQ-029 TAKEN by COND: 000 always 1; 001 ZF; 010 !ZF; 011 CF; 100 !CF; 101 NF; 110 OF; 111 NF^OF (signed less-than).
REQ-030 Write latency SHALL be one cycle: a write sampled at edge n is visible on FLAGS and TAKEN after edge n.

Reset
REQ-031 On RESET at a clock edge: FLAGS=0000, count=0, ERR=0, STACK_EMPTY=1, STACK_FULL=0; RESET overrides all same-cycle requests.
REQ-032 Stack entry contents SHALL need no reset; entries are unreadable while count=0.
REQ-033 RESET asserted mid-sequence, such as between nested SAVEs, SHALL discard all stacked entries.

Structure
REQ-034 A shared cpu_pkg SHALL hold the COND encodings, the flag bit indices (CF=3, OF=2, NF=1, ZF=0) and the default STACK_DEPTH.
REQ-035 A single sub-module, flag_stack (LIFO with push, pop and swap, plus full/empty), SHALL be instantiated once.
REQ-036 Write-source arbitration and the condition decode SHALL remain in flag_ctrl.

Verification
REQ-037 Reset, then ALU_FWE with ALU_FLAGS=1111 and ALU_MASK=0101 -> FLAGS=0101; then COND=111 -> TAKEN=1 (NF=0, OF=1).
REQ-038 LD_FWE=1 with LD_FLAGS=1000 and ALU_FWE=1 with ALU_FLAGS=0001, mask 1111, in the same cycle -> FLAGS=1000.
REQ-039 Four SAVEs with FLAGS set to 0001/0010/0100/1000 before each -> STACK_FULL=1; a fifth SAVE -> ERR=1 and count stays 4; four RESTOREs -> FLAGS 1000, 0100, 0010, 0001.
REQ-040 Empty stack, RESTORE together with LD_FLAGS=0110 -> ERR=1 and FLAGS=0110; CLR_ERR -> ERR=0.
REQ-041 FLAGS=0011 with stack top 1100, SAVE+RESTORE together -> FLAGS=1100, top=0011, count unchanged.
REQ-042 Two SAVEs, RESET, then RESTORE -> ERR=1, FLAGS=0000, STACK_EMPTY=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag bit positions, branch condition codes and
// the default shadow-stack depth.
package cpu_pkg;

  localparam int unsigned FLAG_CF = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_NF = 1;
  localparam int unsigned FLAG_ZF = 0;

  localparam int unsigned DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_CS = 3'b011,
    COND_CC = 3'b100,
    COND_MI = 3'b101,
    COND_VS = 3'b110,
    COND_LT = 3'b111
  } cond_e;

endpackage

// File: rtl/flag_stack.sv
// Shadow LIFO for the flag register: push, pop, and a same-cycle swap of
// the top entry. Requests that would over/underflow are ignored here.
module flag_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       din,
  output logic [3:0]       dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;

  assign empty   = (count == '0);
  assign full    = (count == PTR_W'(DEPTH));
  assign top_idx = IDX_W'(count - PTR_W'(1));
  assign dout    = mem[top_idx];

  // Swap only needs a valid top entry; pushing into a full stack is fine then.
  assign do_swap = push && pop && !empty;
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign wr_idx  = do_swap ? top_idx : count[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + PTR_W'(1);
    end else if (do_pop) begin
      count <= count - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (do_push || do_swap)) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// Flag register with prioritised write sources, a shadow stack for
// interrupt entry/return, sticky stack error and branch condition decode.
module flag_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned PTR_W       = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ALU_FWE,
  input  logic [3:0] ALU_FLAGS,
  input  logic [3:0] ALU_MASK,
  input  logic       LD_FWE,
  input  logic [3:0] LD_FLAGS,
  input  logic       SAVE,
  input  logic       RESTORE,
  input  logic       CLR_ERR,
  input  logic [2:0] COND,
  output logic [3:0] FLAGS,
  output logic       TAKEN,
  output logic       STACK_EMPTY,
  output logic       STACK_FULL,
  output logic       ERR
);

  logic [3:0] stack_top;
  logic       restore_ok;
  logic       underflow;
  logic       overflow;

  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk   (CLK),
    .rst   (RESET),
    .push  (SAVE),
    .pop   (RESTORE),
    .din   (FLAGS),
    .dout  (stack_top),
    .full  (STACK_FULL),
    .empty (STACK_EMPTY)
  );

  assign restore_ok = RESTORE && !STACK_EMPTY;
  assign underflow  = RESTORE && STACK_EMPTY;
  assign overflow   = SAVE && !RESTORE && STACK_FULL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FLAGS <= '0;
      ERR   <= 1'b0;
    end else begin
      if (restore_ok) begin
        FLAGS <= stack_top;
      end else if (LD_FWE) begin
        FLAGS <= LD_FLAGS;
      end else if (ALU_FWE) begin
        FLAGS <= (FLAGS & ~ALU_MASK) | (ALU_FLAGS & ALU_MASK);
      end

      // A new error wins over a same-cycle clear.
      if (underflow || overflow) begin
        ERR <= 1'b1;
      end else if (CLR_ERR) begin
        ERR <= 1'b0;
      end
    end
  end

  always_comb begin
    TAKEN = 1'b1;
    unique case (cond_e'(COND))
      COND_AL: TAKEN = 1'b1;
      COND_EQ: TAKEN = FLAGS[FLAG_ZF];
      COND_NE: TAKEN = !FLAGS[FLAG_ZF];
      COND_CS: TAKEN = FLAGS[FLAG_CF];
      COND_CC: TAKEN = !FLAGS[FLAG_CF];
      COND_MI: TAKEN = FLAGS[FLAG_NF];
      COND_VS: TAKEN = FLAGS[FLAG_OF];
      COND_LT: TAKEN = FLAGS[FLAG_NF] ^ FLAGS[FLAG_OF];
      default: TAKEN = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed self-checking bench for flag_ctrl with hand-computed expectations.
module tb_flag_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALU_FWE;
  logic [3:0] ALU_FLAGS;
  logic [3:0] ALU_MASK;
  logic       LD_FWE;
  logic [3:0] LD_FLAGS;
  logic       SAVE;
  logic       RESTORE;
  logic       CLR_ERR;
  logic [2:0] COND;
  logic [3:0] FLAGS;
  logic       TAKEN;
  logic       STACK_EMPTY;
  logic       STACK_FULL;
  logic       ERR;

  int unsigned checks = 0;
  int unsigned errors = 0;

  flag_ctrl #(
    .STACK_DEPTH (4),
    .PTR_W       (3)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ALU_FWE     (ALU_FWE),
    .ALU_FLAGS   (ALU_FLAGS),
    .ALU_MASK    (ALU_MASK),
    .LD_FWE      (LD_FWE),
    .LD_FLAGS    (LD_FLAGS),
    .SAVE        (SAVE),
    .RESTORE     (RESTORE),
    .CLR_ERR     (CLR_ERR),
    .COND        (COND),
    .FLAGS       (FLAGS),
    .TAKEN       (TAKEN),
    .STACK_EMPTY (STACK_EMPTY),
    .STACK_FULL  (STACK_FULL),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    RESET = 1'b0; ALU_FWE = 1'b0; ALU_FLAGS = '0; ALU_MASK = '0;
    LD_FWE = 1'b0; LD_FLAGS = '0; SAVE = 1'b0; RESTORE = 1'b0; CLR_ERR = 1'b0;
  endtask

  // Apply current inputs at one rising edge, then return inputs to idle.
  task automatic step();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic load(input logic [3:0] v);
    LD_FWE = 1'b1; LD_FLAGS = v;
    step();
  endtask

  logic [3:0] exp_top;

  initial begin
    idle();
    COND = 3'b000;
    @(negedge CLK);

    RESET = 1'b1; step();
    check("rst_flags", 8'(FLAGS), 8'h0);
    check("rst_empty", 8'(STACK_EMPTY), 8'h1);
    check("rst_full",  8'(STACK_FULL), 8'h0);
    check("rst_err",   8'(ERR), 8'h0);
    check("rst_taken_al", 8'(TAKEN), 8'h1);

    ALU_FWE = 1'b1; ALU_FLAGS = 4'b1111; ALU_MASK = 4'b0101; step();
    check("alu_mask", 8'(FLAGS), 8'b0101);
    COND = 3'b111; #1 check("cond_lt", 8'(TAKEN), 8'h1);
    COND = 3'b001; #1 check("cond_eq", 8'(TAKEN), 8'h1);
    COND = 3'b010; #1 check("cond_ne", 8'(TAKEN), 8'h0);
    COND = 3'b011; #1 check("cond_cs", 8'(TAKEN), 8'h0);
    COND = 3'b100; #1 check("cond_cc", 8'(TAKEN), 8'h1);
    COND = 3'b101; #1 check("cond_mi", 8'(TAKEN), 8'h0);
    COND = 3'b110; #1 check("cond_vs", 8'(TAKEN), 8'h1);

    ALU_FWE = 1'b1; ALU_FLAGS = 4'b1010; ALU_MASK = 4'b0000; step();
    check("alu_mask0", 8'(FLAGS), 8'b0101);

    LD_FWE = 1'b1; LD_FLAGS = 4'b1000;
    ALU_FWE = 1'b1; ALU_FLAGS = 4'b0001; ALU_MASK = 4'b1111; step();
    check("ld_over_alu", 8'(FLAGS), 8'b1000);
    COND = 3'b111; #1 check("cond_lt_nf0of0", 8'(TAKEN), 8'h0);

    for (int i = 0; i < 4; i++) begin
      load(4'(1 << i));
      SAVE = 1'b1; step();
    end
    check("push4_full", 8'(STACK_FULL), 8'h1);
    check("push4_err",  8'(ERR), 8'h0);
    SAVE = 1'b1; step();
    check("ovf_err",  8'(ERR), 8'h1);
    check("ovf_full", 8'(STACK_FULL), 8'h1);
    CLR_ERR = 1'b1; step();
    check("ovf_clr", 8'(ERR), 8'h0);
    for (int i = 3; i >= 0; i--) begin
      RESTORE = 1'b1; step();
      exp_top = 4'(1 << i);
      check("pop_seq", 8'(FLAGS), 8'(exp_top));
    end
    check("pop4_empty", 8'(STACK_EMPTY), 8'h1);
    check("pop4_err",   8'(ERR), 8'h0);

    SAVE = 1'b1; LD_FWE = 1'b1; LD_FLAGS = 4'b1111; step();
    check("save_ld_flags", 8'(FLAGS), 8'b1111);
    RESTORE = 1'b1; step();
    check("save_pre_write", 8'(FLAGS), 8'b0001);

    RESTORE = 1'b1; LD_FWE = 1'b1; LD_FLAGS = 4'b0110; step();
    check("unf_err",   8'(ERR), 8'h1);
    check("unf_flags", 8'(FLAGS), 8'b0110);
    CLR_ERR = 1'b1; step();
    check("unf_clr", 8'(ERR), 8'h0);
    CLR_ERR = 1'b1; RESTORE = 1'b1; step();
    check("clr_vs_new_err", 8'(ERR), 8'h1);
    CLR_ERR = 1'b1; step();

    SAVE = 1'b1; RESTORE = 1'b1; LD_FWE = 1'b1; LD_FLAGS = 4'b1001; step();
    check("swap_empty_err",   8'(ERR), 8'h1);
    check("swap_empty_flags", 8'(FLAGS), 8'b1001);
    check("swap_empty_empty", 8'(STACK_EMPTY), 8'h1);
    CLR_ERR = 1'b1; step();

    load(4'b1100);
    SAVE = 1'b1; step();
    load(4'b0011);
    SAVE = 1'b1; RESTORE = 1'b1; step();
    check("swap_flags", 8'(FLAGS), 8'b1100);
    check("swap_empty", 8'(STACK_EMPTY), 8'h0);
    RESTORE = 1'b1; step();
    check("swap_top",   8'(FLAGS), 8'b0011);
    check("swap_count", 8'(STACK_EMPTY), 8'h1);

    load(4'b0101);
    SAVE = 1'b1; step();
    RESTORE = 1'b1; LD_FWE = 1'b1; LD_FLAGS = 4'b1111;
    ALU_FWE = 1'b1; ALU_FLAGS = 4'b1111; ALU_MASK = 4'b1111; step();
    check("restore_over_ld", 8'(FLAGS), 8'b0101);

    SAVE = 1'b1; step();
    SAVE = 1'b1; step();
    RESET = 1'b1; SAVE = 1'b1; LD_FWE = 1'b1; LD_FLAGS = 4'b1111; step();
    check("rst_ovr_flags", 8'(FLAGS), 8'h0);
    check("rst_ovr_empty", 8'(STACK_EMPTY), 8'h1);
    RESTORE = 1'b1; step();
    check("rst_discard_err",   8'(ERR), 8'h1);
    check("rst_discard_flags", 8'(FLAGS), 8'h0);
    check("rst_discard_empty", 8'(STACK_EMPTY), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
